router_pkt_tx: RTL and testbench

- Packet source for the 1x3 router input port.
- A host first loads payload bytes into an internal buffer, then issues a start with a destination address.
- The block then sends, in order, the header byte, the payload bytes and the parity byte on pkt_valid and data_out.
- It obeys the router's busy back-pressure and waits for the router to return to address decode before accepting the next packet.

---
 rtl/router_pkt_tx_if.sv | 37 +++
 rtl/router_pkt_tx.sv | 185 ++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Host/router bus for the packet source of the 1x3 router input port.
//
// Groups every non-clock, non-reset signal of router_pkt_tx:
//   host side   : wr_en, wr_data, start, dest_addr, corrupt_parity, abort
//   router side : busy (back-pressure), pkt_valid, data_out
//   status      : buf_count, tx_idle, done, err
//
// Modports:
//   master - the driver of the packet source (host plus router model)
//   slave  - the packet source itself
interface router_pkt_tx_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [1:0]        dest_addr;
    logic              corrupt_parity;
    logic              abort;
    logic              busy;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_out;
    logic [5:0]        buf_count;
    logic              tx_idle;
    logic              done;
    logic              err;

    modport master (
        output wr_en, wr_data, start, dest_addr, corrupt_parity, abort, busy,
        input  pkt_valid, data_out, buf_count, tx_idle, done, err
    );

    modport slave (
        input  wr_en, wr_data, start, dest_addr, corrupt_parity, abort, busy,
        output pkt_valid, data_out, buf_count, tx_idle, done, err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port.
//
// The host loads payload bytes into an internal buffer while the block is
// idle, then pulses start with a destination address. The block sends the
// header byte {length, addr}, the payload bytes and an XOR parity byte,
// honouring the router's busy back-pressure, and then waits a short gap
// before it accepts the next packet.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - router_pkt_tx_if.slave:
//              wr_en/wr_data    payload load (IDLE only)
//              start/dest_addr  send request, address 0..2
//              corrupt_parity   flip parity bit 0 of this packet
//              abort            drop the current packet
//              busy             router stall, a byte moves only when 0
//              pkt_valid        high for header and payload bytes
//              data_out         header, payload or parity byte
//              buf_count        number of buffered payload bytes
//              tx_idle          high while in IDLE
//              done             one-cycle pulse after parity transfer
//              err              one-cycle pulse on rejected start/overflow
module router_pkt_tx #(
    parameter int DATA_W     = 8,
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    router_pkt_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    localparam logic [5:0] MAX_CNT  = 6'(MAX_LEN);
    // The gap counter saturates at its exit threshold so a long busy stall
    // in GAP can never wrap it back below the threshold.
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            state;
    logic [5:0]        rd_ptr;
    logic [DATA_W-1:0] parity;
    logic              corrupt_q;
    logic [7:0]        gap_cnt;
    logic [5:0]        buf_count_q;
    logic              pkt_valid_q;
    logic [DATA_W-1:0] data_out_q;
    logic              done_q;
    logic              err_q;

    logic [DATA_W-1:0] buffer [0:MAX_LEN-1];

    logic              wr_accept;
    logic              wr_overflow;
    logic [5:0]        count_after_wr;
    logic              start_bad;
    logic [DATA_W-1:0] parity_next;

    // Idle-time load decode. A write in the same cycle as start lands first,
    // so start sees the incremented count. Abort in IDLE wins over both.
    always_comb begin
        wr_accept      = 1'b0;
        wr_overflow    = 1'b0;
        if (state == IDLE && bus.wr_en && !bus.abort) begin
            wr_accept   = (buf_count_q < MAX_CNT);
            wr_overflow = (buf_count_q >= MAX_CNT);
        end
        count_after_wr = wr_accept ? buf_count_q + 6'd1 : buf_count_q;
        start_bad      = (count_after_wr == 6'd0) || (bus.dest_addr == 2'd3);
        parity_next    = parity ^ data_out_q;
    end

    // Payload storage has no reset: its contents only matter below buf_count.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            buffer[buf_count_q] <= bus.wr_data;
        end
    end

    // Packet sequencer with registered outputs. A byte moves at an edge
    // where busy is low; abort outranks any transfer in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            parity      <= '0;
            corrupt_q   <= 1'b0;
            gap_cnt     <= '0;
            buf_count_q <= '0;
            pkt_valid_q <= 1'b0;
            data_out_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.abort) begin
                state       <= IDLE;
                rd_ptr      <= '0;
                parity      <= '0;
                gap_cnt     <= '0;
                buf_count_q <= '0;
                pkt_valid_q <= 1'b0;
                data_out_q  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        buf_count_q <= count_after_wr;
                        if (wr_overflow) begin
                            err_q <= 1'b1;
                        end
                        if (bus.start) begin
                            if (start_bad) begin
                                err_q <= 1'b1;
                            end else begin
                                state       <= HEADER;
                                corrupt_q   <= bus.corrupt_parity;
                                pkt_valid_q <= 1'b1;
                                data_out_q  <= DATA_W'({count_after_wr, bus.dest_addr});
                                parity      <= DATA_W'({count_after_wr, bus.dest_addr});
                            end
                        end
                    end
                    HEADER: begin
                        if (!bus.busy) begin
                            state      <= PAYLOAD;
                            data_out_q <= buffer[0];
                            rd_ptr     <= 6'd1;
                        end
                    end
                    PAYLOAD: begin
                        if (!bus.busy) begin
                            parity <= parity_next;
                            if (rd_ptr == buf_count_q) begin
                                state       <= PARITY;
                                pkt_valid_q <= 1'b0;
                                data_out_q  <= parity_next ^ DATA_W'(corrupt_q);
                            end else begin
                                data_out_q <= buffer[rd_ptr];
                                rd_ptr     <= rd_ptr + 6'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (!bus.busy) begin
                            state       <= GAP;
                            done_q      <= 1'b1;
                            data_out_q  <= '0;
                            buf_count_q <= '0;
                            gap_cnt     <= '0;
                            rd_ptr      <= '0;
                        end
                    end
                    GAP: begin
                        if (gap_cnt < GAP_LAST) begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                        if (gap_cnt >= GAP_LAST && !bus.busy) begin
                            state  <= IDLE;
                            parity <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pkt_valid = pkt_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.buf_count = buf_count_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.tx_idle   = (state == IDLE);

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx.
//
// Inputs change and outputs are sampled on the falling clock edge. The
// expected byte stream of every packet is built from the payload queue:
// header = {length, addr}, then the payload, then the XOR of all of those
// bytes (bit 0 flipped when corrupt_parity is set).
module tb_router_pkt_tx;

    logic clock;
    logic reset;

    router_pkt_tx_if #(.DATA_W(8)) bus ();

    router_pkt_tx #(
        .DATA_W(8),
        .MAX_LEN(63),
        .GAP_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] payload_q[$];
    int         stall_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Write the first cnt bytes of payload_q into the buffer.
    task automatic applyStimulus(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = payload_q[i];
            step();
        end
        bus.wr_en = 1'b0;
        checkOutput("buf_count after load", 32'(bus.buf_count), 32'(cnt));
    endtask

    // Start the buffered packet and follow it to the end, stalling byte k
    // for stall_q[k] cycles. With with_write the last payload byte is
    // written in the same cycle as start.
    task automatic sendPacket(input logic [1:0] addr, input logic corr,
                              input logic with_write, input string tag);
        logic [7:0] exp_q[$];
        logic [7:0] par;
        int         n;
        int         st;
        n = payload_q.size();
        exp_q.delete();
        exp_q.push_back({6'(n), addr});
        foreach (payload_q[i]) exp_q.push_back(payload_q[i]);
        par = 8'h00;
        foreach (exp_q[i]) par = par ^ exp_q[i];
        if (corr) par = par ^ 8'h01;
        exp_q.push_back(par);

        bus.start          = 1'b1;
        bus.dest_addr      = addr;
        bus.corrupt_parity = corr;
        bus.busy           = 1'b0;
        if (with_write) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = payload_q[n-1];
        end
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;

        for (int k = 0; k < exp_q.size(); k++) begin
            st = (k < stall_q.size()) ? stall_q[k] : 0;
            for (int s = 0; s < st; s++) begin
                bus.busy = 1'b1;
                checkOutput($sformatf("%s stall byte %0d", tag, k), 32'(bus.data_out), 32'(exp_q[k]));
                checkOutput($sformatf("%s stall valid %0d", tag, k), 32'(bus.pkt_valid),
                            32'(k < exp_q.size() - 1));
                step();
            end
            bus.busy = 1'b0;
            checkOutput($sformatf("%s byte %0d", tag, k), 32'(bus.data_out), 32'(exp_q[k]));
            checkOutput($sformatf("%s valid %0d", tag, k), 32'(bus.pkt_valid),
                        32'(k < exp_q.size() - 1));
            checkOutput($sformatf("%s early done %0d", tag, k), 32'(bus.done), 32'd0);
            step();
        end
        checkOutput({tag, " done pulse"}, 32'(bus.done), 32'd1);
        checkOutput({tag, " buf_count cleared"}, 32'(bus.buf_count), 32'd0);
        step();
        checkOutput({tag, " done drop"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " gap not idle"}, 32'(bus.tx_idle), 32'd0);
        step();
        checkOutput({tag, " back to idle"}, 32'(bus.tx_idle), 32'd1);
        stall_q.delete();
    endtask

    task automatic fillRandom(input int len);
        payload_q.delete();
        for (int i = 0; i < len; i++) payload_q.push_back(8'($urandom));
    endtask

    initial begin
        int len;
        logic wr_with_start;
        reset              = 1'b1;
        bus.wr_en          = 1'b0;
        bus.wr_data        = 8'h00;
        bus.start          = 1'b0;
        bus.dest_addr      = 2'd0;
        bus.corrupt_parity = 1'b0;
        bus.abort          = 1'b0;
        bus.busy           = 1'b0;
        repeat (2) @(negedge clock);

        checkOutput("reset pkt_valid", 32'(bus.pkt_valid), 32'd0);
        checkOutput("reset data_out", 32'(bus.data_out), 32'd0);
        checkOutput("reset buf_count", 32'(bus.buf_count), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset err", 32'(bus.err), 32'd0);
        checkOutput("reset tx_idle", 32'(bus.tx_idle), 32'd1);
        reset = 1'b0;
        step();

        $display("[TB] basic three-byte packet");
        payload_q = '{8'h11, 8'h22, 8'h33};
        applyStimulus(3);
        sendPacket(2'd1, 1'b0, 1'b0, "basic");

        $display("[TB] same packet with busy stalls");
        applyStimulus(3);
        stall_q = '{2, 0, 3, 0, 0};
        sendPacket(2'd1, 1'b0, 1'b0, "stall");

        $display("[TB] rejected starts");
        bus.start = 1'b1;
        bus.dest_addr = 2'd1;
        step();
        bus.start = 1'b0;
        checkOutput("empty start err", 32'(bus.err), 32'd1);
        checkOutput("empty start valid", 32'(bus.pkt_valid), 32'd0);
        checkOutput("empty start idle", 32'(bus.tx_idle), 32'd1);
        step();
        checkOutput("empty start err drop", 32'(bus.err), 32'd0);
        fillRandom(1);
        applyStimulus(1);
        bus.start = 1'b1;
        bus.dest_addr = 2'd3;
        step();
        bus.start = 1'b0;
        checkOutput("addr3 err", 32'(bus.err), 32'd1);
        checkOutput("addr3 valid", 32'(bus.pkt_valid), 32'd0);
        checkOutput("addr3 idle", 32'(bus.tx_idle), 32'd1);
        checkOutput("addr3 buffer kept", 32'(bus.buf_count), 32'd1);
        step();
        sendPacket(2'd2, 1'b0, 1'b0, "after addr3");

        $display("[TB] full buffer and overflow write");
        fillRandom(63);
        applyStimulus(63);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h5A;
        step();
        bus.wr_en = 1'b0;
        checkOutput("overflow err", 32'(bus.err), 32'd1);
        checkOutput("overflow count", 32'(bus.buf_count), 32'd63);
        step();
        checkOutput("overflow err drop", 32'(bus.err), 32'd0);
        sendPacket(2'd2, 1'b0, 1'b0, "full");

        $display("[TB] corrupted parity");
        payload_q = '{8'hA5};
        applyStimulus(1);
        sendPacket(2'd0, 1'b1, 1'b0, "corrupt");

        $display("[TB] write together with start");
        fillRandom(3);
        applyStimulus(2);
        sendPacket(2'd1, 1'b0, 1'b1, "wr+start");

        $display("[TB] abort mid-payload");
        fillRandom(5);
        applyStimulus(5);
        bus.start = 1'b1;
        bus.dest_addr = 2'd1;
        step();
        bus.start = 1'b0;
        step();
        step();
        checkOutput("abort at byte 2", 32'(bus.data_out), 32'(payload_q[1]));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checkOutput("abort valid", 32'(bus.pkt_valid), 32'd0);
        checkOutput("abort data", 32'(bus.data_out), 32'd0);
        checkOutput("abort count", 32'(bus.buf_count), 32'd0);
        checkOutput("abort idle", 32'(bus.tx_idle), 32'd1);
        checkOutput("abort no done", 32'(bus.done), 32'd0);
        step();
        checkOutput("abort no late done", 32'(bus.done), 32'd0);
        fillRandom(4);
        applyStimulus(4);
        sendPacket(2'd0, 1'b0, 1'b0, "post abort");

        $display("[TB] reset mid-payload");
        fillRandom(4);
        applyStimulus(4);
        bus.start = 1'b1;
        bus.dest_addr = 2'd2;
        step();
        bus.start = 1'b0;
        step();
        step();
        checkOutput("pre reset valid", 32'(bus.pkt_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("reset async valid", 32'(bus.pkt_valid), 32'd0);
        checkOutput("reset async count", 32'(bus.buf_count), 32'd0);
        checkOutput("reset async idle", 32'(bus.tx_idle), 32'd1);
        #1 reset = 1'b0;
        step();
        checkOutput("reset no done", 32'(bus.done), 32'd0);
        fillRandom(2);
        applyStimulus(2);
        sendPacket(2'd2, 1'b0, 1'b0, "post reset");

        $display("[TB] randomized packets");
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(1, 20);
            fillRandom(len);
            wr_with_start = 1'($urandom_range(0, 1));
            applyStimulus(wr_with_start ? len - 1 : len);
            stall_q.delete();
            for (int k = 0; k < len + 2; k++) stall_q.push_back($urandom_range(0, 2));
            sendPacket(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), wr_with_start,
                       $sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
